ec2_control_unit: RTL and testbench
===================================

// Module: ec2_control_unit
// PURPOSE
//  Multi-cycle control FSM for the EC2 16-bit accumulator CPU.
//  Sequences fetch/decode/execute over the shared PC/IR/A/memory datapath inside ec2top.
//  Waits on a memory ready handshake and drives every datapath load/select strobe.
//  Asserts Halt on a HALT instruction or on a memory timeout.
// PARAMETERS
//  MEM_TIMEOUT  15  max consecutive MemReady=0 cycles in one access before fault; 0 = never time out
//  OPW          4   opcode width (IR[15:12])
// PORTS
//  Clock      in   1    system clock, all state on rising edge
//  Reset      in   1    synchronous, active-high; overrides everything
//  IR_opcode  in   OPW  opcode field of IR (valid from DECODE onward)
//  Aeq0       in   1    accumulator == 0
//  Apos       in   1    accumulator > 0 (signed, strictly positive)
//  MemReady   in   1    memory completes current read/write this cycle
//  IRload     out  1    load IR from memory data
//  PCinc      out  1    PC <= PC+1
//  PCload     out  1    PC <= IR[11:0]
//  AddrSel    out  1    memory address: 0=PC, 1=IR[11:0]
//  MemRead    out  1    memory read request
//  MemWrite   out  1    memory write request (data = A)
//  Asel       out  2    A source: 00=ALU, 01=Input, 10=memory data
//  ALUsub     out  1    ALU op: 0=A+M, 1=A-M
//  Aload      out  1    load A from Asel source
//  OutLoad    out  1    Output register <= A
//  Halt       out  1    registered; sticky until Reset
//  Fault      out  1    registered; memory timeout; sticky until Reset
//  State      out  3    current state (debug)
// BEHAVIOUR
//  States: START=0, FETCH=1, DECODE=2, EXEC=3, HALT=4, FAULT=5.
//  Strobes are combinational from the registered state, latched opcode op_q and MemReady.
//  Reset: state=START, op_q=0, wait counter=0, Halt=0, Fault=0, all strobes 0.
//  START: one idle cycle, -> FETCH.
//  FETCH: AddrSel=0, MemRead=1 while waiting.
//    On the MemReady cycle: IRload=1 and PCinc=1 in the same cycle, -> DECODE.
//  DECODE: no strobes; op_q <= IR_opcode; -> EXEC.
//  EXEC by op_q:
//    0 LOAD: AddrSel=1, MemRead=1; on MemReady: Asel=10, Aload=1 -> FETCH.
//    2 ADD / 3 SUB: as LOAD but Asel=00; ALUsub = (op_q==3).
//    1 STORE: AddrSel=1, MemWrite=1 held until MemReady -> FETCH.
//    4 INPUT: Asel=01, Aload=1, one cycle -> FETCH.
//    5 OUTPUT: OutLoad=1, one cycle -> FETCH.
//    6 JUMP: PCload=1. 7 JZ: PCload=Aeq0. 8 JPOS: PCload=Apos. Each one cycle -> FETCH.
//    15 HALT: -> HALT. Other opcodes: NOP, one cycle -> FETCH.
//  HALT: Halt=1, no strobes, no memory requests; stays until Reset.
//  Zero-wait memory: MemReady may be high on the first request cycle; access completes in 1 cycle.
//    INPUT/OUTPUT/JUMP then take 3 cycles; LOAD/ADD/SUB/STORE take 3 + wait cycles.
//  Every strobe is a single-cycle pulse; Aload/IRload never repeat within one access.
//  Timeout: counter clears on entering FETCH or EXEC and increments each request cycle with MemReady=0.
//    When counter reaches MEM_TIMEOUT -> FAULT (Fault=1, Halt=1, no strobes) until Reset.
//  Reset mid-access: state=START at the next edge; MemRead/MemWrite low from that edge; no partial strobe.
// TESTING
//  1 Reset high 2 cycles, MemReady=1 -> State=0 and all outputs 0; next cycle FETCH with MemRead=IRload=PCinc=1.
//  2 Opcodes INPUT then OUTPUT, zero-wait -> Aload=1 with Asel=01 in cycle 3; OutLoad=1 in cycle 6; no other strobes.
//  3 LOAD with MemReady delayed 3 cycles -> AddrSel=1, MemRead=1 held 4 cycles; single Aload pulse (Asel=10) in the 4th.
//  4 JZ with Aeq0=0 -> no PCload; JZ with Aeq0=1 -> one PCload pulse; JPOS with Apos=1 -> one PCload pulse.
//  5 HALT (4'hF) -> Halt=1 for 20 following cycles, MemRead=0 throughout; Reset -> Halt=0, State=START.
//  6 MEM_TIMEOUT=4, MemReady stuck 0 in FETCH -> Fault=Halt=1 after 4 wait cycles; Reset during LOAD wait -> START next edge.

Source files
------------

// File: rtl/ec2_control_unit_if.sv
// Bundle of signals between the EC2 control unit and its datapath.
// The master side is the controller: it reads status and drives the strobes.
interface ec2_control_unit_if #(
  parameter int OPW = 4
);
  // Datapath status into the controller
  logic [OPW-1:0] IR_opcode;
  logic           Aeq0;
  logic           Apos;
  logic           MemReady;
  // Datapath strobes and selects from the controller
  logic           IRload;
  logic           PCinc;
  logic           PCload;
  logic           AddrSel;
  logic           MemRead;
  logic           MemWrite;
  logic [1:0]     Asel;
  logic           ALUsub;
  logic           Aload;
  logic           OutLoad;
  logic           Halt;
  logic           Fault;
  logic [2:0]     State;

  modport master (
    input  IR_opcode, Aeq0, Apos, MemReady,
    output IRload, PCinc, PCload, AddrSel, MemRead, MemWrite,
           Asel, ALUsub, Aload, OutLoad, Halt, Fault, State
  );

  modport slave (
    output IR_opcode, Aeq0, Apos, MemReady,
    input  IRload, PCinc, PCload, AddrSel, MemRead, MemWrite,
           Asel, ALUsub, Aload, OutLoad, Halt, Fault, State
  );
endinterface

// File: rtl/ec2_control_unit.sv
// Multi-cycle fetch/decode/execute controller for the EC2 accumulator CPU.
// Strobes are decoded from the registered state, the opcode latched in
// DECODE and the memory ready handshake. A watchdog counts unanswered
// memory request cycles and parks the machine in FAULT when it expires.
module ec2_control_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter int OPW         = 4
) (
  input logic                Clock,
  input logic                Reset,
  ec2_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  // Counter is one bit wider on the increment so the limit compare never wraps
  localparam int          CW       = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW:0] TO_LIMIT = (CW + 1)'(MEM_TIMEOUT);

  localparam logic [OPW-1:0] OP_LOAD   = OPW'(0);
  localparam logic [OPW-1:0] OP_STORE  = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD    = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB    = OPW'(3);
  localparam logic [OPW-1:0] OP_INPUT  = OPW'(4);
  localparam logic [OPW-1:0] OP_OUTPUT = OPW'(5);
  localparam logic [OPW-1:0] OP_JUMP   = OPW'(6);
  localparam logic [OPW-1:0] OP_JZ     = OPW'(7);
  localparam logic [OPW-1:0] OP_JPOS   = OPW'(8);
  localparam logic [OPW-1:0] OP_HALT   = OPW'(15);

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           halt_q, halt_d;
  logic           fault_q, fault_d;

  logic [CW:0]    cnt_inc;
  logic           req_wait;
  logic           ir_load, pc_inc, pc_load, addr_sel, mem_read, mem_write;
  logic [1:0]     a_sel;
  logic           alu_sub, a_load, out_load;

  // Next-state, opcode latch, watchdog and strobe decode
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    cnt_inc   = {1'b0, cnt_q} + (CW + 1)'(1);
    req_wait  = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    addr_sel  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    a_sel     = 2'b00;
    alu_sub   = 1'b0;
    a_load    = 1'b0;
    out_load  = 1'b0;

    case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_read = 1'b1;
        if (bus.MemReady) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = ST_DECODE;
        end else begin
          req_wait = 1'b1;
        end
      end
      ST_DECODE: begin
        op_d    = bus.IR_opcode;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (op_q)
          OP_LOAD, OP_ADD, OP_SUB: begin
            addr_sel = 1'b1;
            mem_read = 1'b1;
            if (bus.MemReady) begin
              // Data selects only matter on the cycle A actually loads
              a_sel   = (op_q == OP_LOAD) ? 2'b10 : 2'b00;
              alu_sub = (op_q == OP_SUB);
              a_load  = 1'b1;
            end else begin
              req_wait = 1'b1;
              state_d  = ST_EXEC;
            end
          end
          OP_STORE: begin
            addr_sel  = 1'b1;
            mem_write = 1'b1;
            if (!bus.MemReady) begin
              req_wait = 1'b1;
              state_d  = ST_EXEC;
            end
          end
          OP_INPUT: begin
            a_sel  = 2'b01;
            a_load = 1'b1;
          end
          OP_OUTPUT: out_load = 1'b1;
          OP_JUMP:   pc_load  = 1'b1;
          OP_JZ:     pc_load  = bus.Aeq0;
          OP_JPOS:   pc_load  = bus.Apos;
          OP_HALT:   state_d  = ST_HALT;
          default:   state_d  = ST_FETCH;
        endcase
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_START;
    endcase

    // A MEM_TIMEOUT of zero disables the watchdog entirely
    if (req_wait && (MEM_TIMEOUT != 0)) begin
      cnt_d = cnt_inc[CW-1:0];
      if (cnt_inc == TO_LIMIT) state_d = ST_FAULT;
    end

    // Each new memory access starts with a fresh wait budget
    if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_EXEC))) cnt_d = '0;

    // Halt/Fault are registered views of the terminal states
    halt_d  = (state_d == ST_HALT) || (state_d == ST_FAULT);
    fault_d = (state_d == ST_FAULT);
  end

  // State, opcode, watchdog and status registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_START;
      op_q    <= '0;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      fault_q <= fault_d;
    end
  end

  assign bus.IRload   = ir_load;
  assign bus.PCinc    = pc_inc;
  assign bus.PCload   = pc_load;
  assign bus.AddrSel  = addr_sel;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.Asel     = a_sel;
  assign bus.ALUsub   = alu_sub;
  assign bus.Aload    = a_load;
  assign bus.OutLoad  = out_load;
  assign bus.Halt     = halt_q;
  assign bus.Fault    = fault_q;
  assign bus.State    = state_q;

endmodule

// File: tb/tb_ec2_control_unit.sv
// Bench for the EC2 control unit: directed scenarios followed by a random
// instruction stream. Each instruction is expanded into its expected
// cycle-by-cycle output vectors from the instruction semantics.
module tb_ec2_control_unit;

  logic Clock;
  logic Reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  ec2_control_unit_if #(.OPW(4)) bus ();

  ec2_control_unit #(.MEM_TIMEOUT(4), .OPW(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Observed outputs packed into one vector
  logic [15:0] outv;
  assign outv = {bus.IRload, bus.PCinc, bus.PCload, bus.AddrSel, bus.MemRead, bus.MemWrite,
                 bus.Asel, bus.ALUsub, bus.Aload, bus.OutLoad, bus.Halt, bus.Fault, bus.State};

  localparam logic [15:0] B_IRL    = 16'h8000;
  localparam logic [15:0] B_PCI    = 16'h4000;
  localparam logic [15:0] B_PCL    = 16'h2000;
  localparam logic [15:0] B_ADS    = 16'h1000;
  localparam logic [15:0] B_MR     = 16'h0800;
  localparam logic [15:0] B_MW     = 16'h0400;
  localparam logic [15:0] B_AS_MEM = 16'h0200;
  localparam logic [15:0] B_AS_IN  = 16'h0100;
  localparam logic [15:0] B_SUB    = 16'h0080;
  localparam logic [15:0] B_AL     = 16'h0040;
  localparam logic [15:0] B_OL     = 16'h0020;
  localparam logic [15:0] B_H      = 16'h0010;
  localparam logic [15:0] B_F      = 16'h0008;
  localparam logic [15:0] S_START  = 16'd0;
  localparam logic [15:0] S_FETCH  = 16'd1;
  localparam logic [15:0] S_DECODE = 16'd2;
  localparam logic [15:0] S_EXEC   = 16'd3;
  localparam logic [15:0] S_HALT   = 16'd4;
  localparam logic [15:0] S_FAULT  = 16'd5;

  function automatic logic [3:0] rop();
    return 4'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [15:0] expv);
    n_tests++;
    assert (outv === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, outv, expv);
    end
  endtask

  // Drive one cycle of inputs, check the combinational outputs, advance a clock
  task automatic step(input logic mr, input logic [3:0] op, input logic z, input logic p,
                      input logic [15:0] expv, input string tag);
    bus.MemReady  = mr;
    bus.IR_opcode = op;
    bus.Aeq0      = z;
    bus.Apos      = p;
    #1;
    chk(tag, expv);
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset(input string tag);
    Reset        = 1'b1;
    bus.MemReady = 1'b1;
    @(posedge Clock); #1;
    chk($sformatf("%s/rst1", tag), 16'h0000);
    @(posedge Clock); #1;
    chk($sformatf("%s/rst2", tag), 16'h0000);
    Reset = 1'b0;
    @(posedge Clock); #1;
  endtask

  // One full instruction: wf fetch waits, decode, then execute with we memory waits
  task automatic run_instr(input logic [3:0] op, input int wf, input int we,
                           input logic z, input logic p, input string tag);
    logic [15:0] wait_v, done_v;
    logic        is_mem;
    for (int i = 0; i < wf; i++) step(1'b0, rop(), z, p, B_MR | S_FETCH, $sformatf("%s/fwait%0d", tag, i));
    step(1'b1, rop(), z, p, B_MR | B_IRL | B_PCI | S_FETCH, $sformatf("%s/fetch", tag));
    step(rbit(), op, z, p, S_DECODE, $sformatf("%s/decode", tag));
    is_mem = 1'b0;
    wait_v = S_EXEC;
    done_v = S_EXEC;
    case (op)
      4'd0:  begin is_mem = 1'b1; wait_v = B_ADS | B_MR | S_EXEC; done_v = wait_v | B_AS_MEM | B_AL; end
      4'd2:  begin is_mem = 1'b1; wait_v = B_ADS | B_MR | S_EXEC; done_v = wait_v | B_AL; end
      4'd3:  begin is_mem = 1'b1; wait_v = B_ADS | B_MR | S_EXEC; done_v = wait_v | B_AL | B_SUB; end
      4'd1:  begin is_mem = 1'b1; wait_v = B_ADS | B_MW | S_EXEC; done_v = wait_v; end
      4'd4:  done_v = B_AS_IN | B_AL | S_EXEC;
      4'd5:  done_v = B_OL | S_EXEC;
      4'd6:  done_v = B_PCL | S_EXEC;
      4'd7:  done_v = (z ? B_PCL : 16'h0) | S_EXEC;
      4'd8:  done_v = (p ? B_PCL : 16'h0) | S_EXEC;
      default: done_v = S_EXEC;
    endcase
    if (is_mem) begin
      for (int i = 0; i < we; i++) step(1'b0, rop(), z, p, wait_v, $sformatf("%s/ewait%0d", tag, i));
      step(1'b1, rop(), z, p, done_v, $sformatf("%s/exec", tag));
    end else begin
      step(rbit(), rop(), z, p, done_v, $sformatf("%s/exec", tag));
    end
  endtask

  initial begin
    logic [3:0] op;
    Reset         = 1'b1;
    bus.MemReady  = 1'b1;
    bus.IR_opcode = 4'h0;
    bus.Aeq0      = 1'b0;
    bus.Apos      = 1'b0;

    // Reset, then the first fetch completes with zero wait
    do_reset("init");

    // INPUT then OUTPUT, zero-wait memory
    run_instr(4'd4, 0, 0, 1'b0, 1'b0, "input");
    run_instr(4'd5, 0, 0, 1'b0, 1'b0, "output");

    // Memory ops with delayed ready
    run_instr(4'd0, 0, 3, 1'b0, 1'b0, "load_w3");
    run_instr(4'd1, 1, 2, 1'b0, 1'b0, "store_w2");
    run_instr(4'd3, 2, 1, 1'b0, 1'b0, "sub_w1");
    run_instr(4'd2, 0, 0, 1'b0, 1'b0, "add_w0");

    // Branches
    run_instr(4'd7, 0, 0, 1'b0, 1'b1, "jz_not");
    run_instr(4'd7, 0, 0, 1'b1, 1'b0, "jz_take");
    run_instr(4'd8, 0, 0, 1'b0, 1'b1, "jpos_take");
    run_instr(4'd8, 0, 0, 1'b1, 1'b0, "jpos_not");
    run_instr(4'd6, 0, 0, 1'b0, 1'b0, "jump");
    run_instr(4'd11, 0, 0, 1'b0, 1'b0, "nop");

    // Random instruction stream, waits kept below the watchdog limit
    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(0, 14));
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rbit(), rbit(),
                $sformatf("rnd%0d_op%0d", k, op));
    end

    // HALT is sticky and silent on the memory bus
    run_instr(4'hF, 0, 0, 1'b0, 1'b0, "halt");
    for (int i = 0; i < 20; i++) step(rbit(), rop(), rbit(), rbit(), B_H | S_HALT, $sformatf("halt_hold%0d", i));
    do_reset("after_halt");

    // Fetch watchdog: 4 unanswered request cycles lead to FAULT
    for (int i = 0; i < 4; i++) step(1'b0, rop(), 1'b0, 1'b0, B_MR | S_FETCH, $sformatf("fto_wait%0d", i));
    for (int i = 0; i < 3; i++) step(rbit(), rop(), 1'b0, 1'b0, B_H | B_F | S_FAULT, $sformatf("fto_fault%0d", i));
    do_reset("after_fault");

    // Execute watchdog on an ADD operand read
    step(1'b1, rop(), 1'b0, 1'b0, B_MR | B_IRL | B_PCI | S_FETCH, "eto/fetch");
    step(1'b0, 4'd2, 1'b0, 1'b0, S_DECODE, "eto/decode");
    for (int i = 0; i < 4; i++) step(1'b0, rop(), 1'b0, 1'b0, B_ADS | B_MR | S_EXEC, $sformatf("eto_wait%0d", i));
    step(1'b1, rop(), 1'b0, 1'b0, B_H | B_F | S_FAULT, "eto_fault");
    do_reset("after_efault");

    // Reset in the middle of a LOAD wait returns to START on the next edge
    step(1'b1, rop(), 1'b0, 1'b0, B_MR | B_IRL | B_PCI | S_FETCH, "rmid/fetch");
    step(1'b0, 4'd0, 1'b0, 1'b0, S_DECODE, "rmid/decode");
    step(1'b0, rop(), 1'b0, 1'b0, B_ADS | B_MR | S_EXEC, "rmid/wait0");
    Reset = 1'b1;
    step(1'b0, rop(), 1'b0, 1'b0, B_ADS | B_MR | S_EXEC, "rmid/wait1");
    Reset = 1'b0;
    step(1'b1, rop(), 1'b0, 1'b0, S_START, "rmid/start");
    run_instr(4'd4, 0, 0, 1'b0, 1'b0, "post_rmid_input");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a stuck simulation
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
